// File: rtl/vs_rr_mux_arb.sv
// vs_rr_mux_arb: four-requester round-robin arbiter that muxes one packet at a
// time onto a shared valid/ready channel. A grant is locked from the first
// beat until the beat carrying last; then one IDLE cycle re-arbitrates.
// Optional stall timeout is compiled in with the macro VS_ARB_TIMEOUT_EN.
module vs_rr_mux_arb #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req_valid,
    input  logic [3:0]       req_last,
    input  logic [WIDTH-1:0] d_in_0,
    input  logic [WIDTH-1:0] d_in_1,
    input  logic [WIDTH-1:0] d_in_2,
    input  logic [WIDTH-1:0] d_in_3,
    output logic [3:0]       req_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] d_out,
    output logic             out_last,
    input  logic             out_ready,
    output logic [1:0]       select,
    output logic             busy,
    output logic             timeout_err
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state_reg;
    logic [1:0] select_reg;
    logic [1:0] ptr_reg;
    logic       busy_reg;

    logic [WIDTH-1:0] d_in_arr [4];
    logic [1:0]       cand [4];
    logic [3:0]       cand_valid;
    logic [1:0]       pick_next;
    logic             sel_valid;
    logic             sel_last;
    logic             beat;

    if (TIMEOUT < 1) begin : g_param_check
        $error("vs_rr_mux_arb: TIMEOUT must be at least 1");
    end

`ifdef VS_ARB_TIMEOUT_EN
    // Counter only needs to reach TIMEOUT-1; the cycle that would hit TIMEOUT releases.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] stall_cnt_reg;
    logic          timeout_err_reg;

    assign timeout_err = timeout_err_reg;
`else
    assign timeout_err = 1'b0;
`endif

    assign d_in_arr[0] = d_in_0;
    assign d_in_arr[1] = d_in_1;
    assign d_in_arr[2] = d_in_2;
    assign d_in_arr[3] = d_in_3;

    // Candidate gi is the requester (gi+1) places after the last winner, so
    // candidate 0 has the highest priority and candidate 3 is the last winner.
    for (genvar gi = 0; gi < 4; gi++) begin : g_cand
        assign cand[gi]       = ptr_reg + 2'(gi + 1);
        assign cand_valid[gi] = req_valid[cand[gi]];
    end

    // Pick the highest-priority valid candidate; falls back to the last winner.
    always_comb begin
        pick_next = cand[3];
        for (int k = 2; k >= 0; k--) begin
            if (cand_valid[k]) begin
                pick_next = cand[k];
            end
        end
    end

    assign sel_valid = req_valid[select_reg];
    assign sel_last  = req_last[select_reg];
    assign out_valid = (state_reg == BUSY) && sel_valid;
    assign out_last  = (state_reg == BUSY) && sel_last;
    assign d_out     = d_in_arr[select_reg];
    assign beat      = out_valid && out_ready;

    // Only the granted requester sees the downstream ready, and only while BUSY.
    for (genvar gi = 0; gi < 4; gi++) begin : g_ready
        assign req_ready[gi] = (state_reg == BUSY) && (select_reg == 2'(gi)) && out_ready;
    end

    assign select = select_reg;
    assign busy   = busy_reg;

    // Arbitration FSM: IDLE picks a winner, BUSY holds it until the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            select_reg      <= 2'd0;
            ptr_reg         <= 2'd3;
            busy_reg        <= 1'b0;
`ifdef VS_ARB_TIMEOUT_EN
            stall_cnt_reg   <= '0;
            timeout_err_reg <= 1'b0;
`endif
        end else begin
`ifdef VS_ARB_TIMEOUT_EN
            timeout_err_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (|req_valid) begin
                        select_reg    <= pick_next;
                        state_reg     <= BUSY;
                        busy_reg      <= 1'b1;
`ifdef VS_ARB_TIMEOUT_EN
                        stall_cnt_reg <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (beat && sel_last) begin
                        ptr_reg   <= select_reg;
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
`ifdef VS_ARB_TIMEOUT_EN
                    // Only cycles where the owner has nothing to offer count as stalls.
                    if (beat) begin
                        stall_cnt_reg <= '0;
                    end else if (!sel_valid) begin
                        if (stall_cnt_reg == CW'(TIMEOUT - 1)) begin
                            stall_cnt_reg   <= '0;
                            ptr_reg         <= select_reg;
                            state_reg       <= IDLE;
                            busy_reg        <= 1'b0;
                            timeout_err_reg <= 1'b1;
                        end else begin
                            stall_cnt_reg <= stall_cnt_reg + CW'(1);
                        end
                    end
`endif
                end
            endcase
        end
    end

endmodule

// File: doc/vs_rr_mux_arb.md
VS_RR_MUX_ARB -- requirements
Module: vs_rr_mux_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the data width of every channel.
REQ-002 The block SHALL have parameter TIMEOUT, default 16, meaning the stall cycles before forced release (used only when VS_ARB_TIMEOUT_EN is defined).
REQ-003 Port clk SHALL be input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n SHALL be input, 1 bit, the asynchronous active-low reset.
REQ-005 Port req_valid SHALL be input, 4 bits, the per-requester valid.
REQ-006 Port req_last SHALL be input, 4 bits, the per-requester last-beat-of-packet flag.
REQ-007 Ports d_in_0..d_in_3 SHALL each be input, WIDTH bits, the requester data.
REQ-008 Port req_ready SHALL be output, 4 bits, the per-requester ready.
REQ-009 Port out_valid SHALL be output, 1 bit, the shared-channel valid.
REQ-010 Port d_out SHALL be output, WIDTH bits, the shared-channel data.
REQ-011 Port out_last SHALL be output, 1 bit, the shared-channel last flag.
REQ-012 Port out_ready SHALL be input, 1 bit, the downstream ready.
REQ-013 Port select SHALL be output, 2 bits, the current grant index.
REQ-014 Port busy SHALL be output, 1 bit, high while in state BUSY.
REQ-015 Port timeout_err SHALL be output, 1 bit, a one-cycle pulse on forced release.

Function
REQ-016 The FSM SHALL have exactly two states, IDLE and BUSY.
REQ-017 In IDLE, if any req_valid bit is 1, the block SHALL choose the first valid requester in search order ptr+1, ptr+2, ptr+3, ptr (mod 4), register it into select, and enter BUSY on the next edge.
REQ-018 In IDLE, out_valid, out_last and req_ready SHALL be 0, and select SHALL hold its previous value.
REQ-019 In BUSY, out_valid, d_out and out_last SHALL combinationally equal req_valid[select], d_in_<select> and req_last[select].
REQ-020 In BUSY, req_ready[select] SHALL equal out_ready, and all other req_ready bits SHALL be 0.
REQ-021 A beat SHALL be defined as out_valid&out_ready; the grant SHALL stay locked across beats until a beat with out_last=1 occurs.
REQ-022 On a beat with out_last=1, the block SHALL load ptr with select and return to IDLE; re-arbitration costs exactly one IDLE cycle (minimum 1-cycle gap between packets).
REQ-023 Requests arriving in BUSY SHALL NOT change select; non-granted requesters SHALL stall with ready=0.
REQ-024 If req_valid[select] drops mid-packet, out_valid SHALL be 0 and the grant SHALL be retained.
REQ-025 Fairness: with all four requesting continuously, grants SHALL rotate 0,1,2,3,0,...

Reset
REQ-026 Asserting rst_n=0 SHALL immediately force state IDLE, select=0, ptr=3, timeout counter=0, timeout_err=0, busy=0, out_valid=0 and req_ready=0.
REQ-027 Reset asserted mid-packet SHALL abandon the packet with no further beats; after release, the first arbitration SHALL favour requester 0.

Configuration
REQ-028 With macro VS_ARB_TIMEOUT_EN defined, a counter SHALL increment each BUSY cycle in which req_valid[select]=0, and SHALL clear on any beat and on entry to BUSY.
REQ-029 With VS_ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT, the block SHALL return to IDLE, load ptr with select, and pulse timeout_err for exactly one cycle.
REQ-030 Without VS_ARB_TIMEOUT_EN, no counter SHALL exist, timeout_err SHALL be tied to 0, the port list SHALL be unchanged, and the grant SHALL wait indefinitely.

Verification
REQ-031 The bench SHALL reset, then drive req_valid=4'b0100 with a 3-beat packet and out_ready=1 -> select=2 after 1 cycle, then 3 beats on d_out, then busy=0.
REQ-032 The bench SHALL hold req_valid=4'b1111 with 1-beat packets -> grant order 0,1,2,3,0, each separated by one IDLE cycle.
REQ-033 The bench SHALL grant requester 1 and raise req_valid[3] mid-packet -> select stays 1 and req_ready[3]=0 until requester 1's last beat.
REQ-034 The bench SHALL toggle out_ready 1,0,1 during a packet -> d_out and out_valid hold while out_ready=0, with no beat lost or duplicated.
REQ-035 With VS_ARB_TIMEOUT_EN and TIMEOUT=4, the bench SHALL drop the granted requester's valid -> timeout_err pulses once after 4 stall cycles and busy=0.
REQ-036 The bench SHALL assert rst_n=0 mid-packet on requester 2 -> out_valid=0 and select=0 immediately, and the next grant goes to requester 0 when requesters 0 and 2 both request.
